// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scanner.
//   state_t     scanner FSM states
//   KEY_*       key-index map boundaries (hex 0-15, operators 16-19, equals 20)
//   OP_*        operator codes carried on opcode
//   lowest_row  index of the lowest active-low row (0 when none is low)
//   key_index   col*NUM_ROWS + row
//   next_col    column rotation with wrap
`timescale 1ns/1ps
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} state_t;

   localparam int KEY_OP_BASE = 16;
   localparam int KEY_EQ      = 20;
   localparam int NUM_COLS    = 5;
   localparam int NUM_ROWS    = 5;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_AND = 2'd3;

   function automatic logic [2:0] lowest_row(input logic [NUM_ROWS-1:0] rows_n);
      logic [2:0] r;
      r = 3'd0;
      for (int i = NUM_ROWS-1; i >= 0; i--)
         if (!rows_n[i]) r = 3'(i);
      return r;
   endfunction

   function automatic logic [4:0] key_index(input logic [2:0] col, input logic [2:0] row);
      return 5'(col) * 5'(NUM_ROWS) + 5'(row);
   endfunction

   function automatic logic [2:0] next_col(input logic [2:0] col);
      return (col == 3'(NUM_COLS-1)) ? 3'd0 : col + 3'd1;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the decoded event outputs.
//   row_n   keypad row sense (active-low, asynchronous)
//   col_n   column drive (active-low one-hot)
//   newhex/hexcode, newop/opcode, eq   single-cycle key events
// master = scanner side, slave = keypad/consumer side.
`timescale 1ns/1ps
interface keypad_scanner_if;
   logic [4:0] row_n;
   logic [4:0] col_n;
   logic       newhex;
   logic [3:0] hexcode;
   logic       newop;
   logic [1:0] opcode;
   logic       eq;

   modport master (input row_n, output col_n, newhex, hexcode, newop, opcode, eq);
   modport slave  (output row_n, input col_n, newhex, hexcode, newop, opcode, eq);
endinterface

// File: rtl/key_sync.sv
// key_sync: 2-flop synchroniser for the asynchronous keypad rows.
//   clock  system clock
//   reset  async active-low; both stages reset to all-ones (no key pressed)
//   d      raw row_n
//   q      synchronised row_n
`timescale 1ns/1ps
module key_sync (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] d,
   output logic [4:0] q
);

   logic [4:0] meta;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 5x5 active-low matrix keypad, debounces press and
// release, and emits one event pulse per press (newhex, newop or eq).
//   clock  system clock, rising edge
//   reset  async active-low
//   kp     keypad_scanner_if.master: row_n in, col_n and events out
// Optional build macro KEYPAD_AUTOREPEAT_EN adds REPEAT_CYCLES: a hex key
// held in HOLD re-emits newhex every REPEAT_CYCLES cycles after EMIT.
`timescale 1ns/1ps
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
`ifdef KEYPAD_AUTOREPEAT_EN
   , parameter int REPEAT_CYCLES = 25000000
`endif
) (
   input  logic             clock,
   input  logic             reset,
   keypad_scanner_if.master kp
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_TERM   = CNT_W'(DEBOUNCE_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [CNT_W-1:0] deb_q, deb_d;
   logic [2:0]       col_q, col_d;
   logic [2:0]       lrow_q, lrow_d;
   logic [3:0]       hex_q, hex_d;
   logic [1:0]       op_q, op_d;

   logic [4:0] row_s;
   logic       any_low, latched_low, good_press;
   logic [4:0] key_idx;
   logic       is_hex, is_op, is_eq, emit_now;

   key_sync u_sync (.clock(clock), .reset(reset), .d(kp.row_n), .q(row_s));

   assign any_low     = ~&row_s;
   assign latched_low = ~row_s[lrow_q];
   // Still the same key: latched row low and nothing lower-indexed low.
   assign good_press  = any_low && (lowest_row(row_s) == lrow_q);
   assign key_idx     = key_index(col_q, lrow_q);
   assign is_hex      = key_idx < 5'(KEY_OP_BASE);
   assign is_op       = !is_hex && (key_idx < 5'(KEY_EQ));
   assign is_eq       = key_idx == 5'(KEY_EQ);

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      deb_d   = deb_q;
      col_d   = col_q;
      lrow_d  = lrow_q;
      hex_d   = hex_q;
      op_d    = op_q;
      case (state_q)
         SCAN: begin
            if (dwell_q >= DWELL_LAST) begin
               dwell_d = '0;
               if (any_low) begin
                  lrow_d  = lowest_row(row_s);
                  deb_d   = '0;
                  state_d = DEBOUNCE;
               end else begin
                  col_d = next_col(col_q);
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (good_press) begin
               if (deb_q >= DEB_LAST) begin
                  deb_d   = DEB_TERM;
                  state_d = EMIT;
                  // Codes are registered on entry so they are valid with the pulse.
                  // Operators 16..19 carry index-16 in their low two bits.
                  if (is_hex) hex_d = key_idx[3:0];
                  if (is_op)  op_d  = key_idx[1:0];
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end else begin
               state_d = SCAN;
               col_d   = next_col(col_q);
               dwell_d = '0;
            end
         end
         EMIT: begin
            deb_d   = '0;
            state_d = HOLD;
         end
         HOLD: begin
            if (latched_low) begin
               deb_d = '0;
            end else if (deb_q >= DEB_LAST) begin
               deb_d   = DEB_TERM;
               state_d = SCAN;
               col_d   = next_col(col_q);
               dwell_d = '0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= SCAN;
         dwell_q <= '0;
         deb_q   <= '0;
         col_q   <= '0;
         lrow_q  <= '0;
         hex_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         deb_q   <= deb_d;
         col_q   <= col_d;
         lrow_q  <= lrow_d;
         hex_q   <= hex_d;
         op_q    <= op_d;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RPT_W-1:0] RPT_TERM = RPT_W'(REPEAT_CYCLES);

   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             rpt_fire;

   // rpt_q equals cycles elapsed since EMIT (or since the last repeat).
   assign rpt_fire = (state_q == HOLD) && is_hex && latched_low && (rpt_q == RPT_TERM);

   always_comb begin
      rpt_d = '0;
      if (state_q == EMIT) begin
         rpt_d = RPT_W'(1);
      end else if (state_q == HOLD && latched_low) begin
         if (rpt_fire)              rpt_d = RPT_W'(1);
         else if (rpt_q < RPT_TERM) rpt_d = rpt_q + 1'b1;
         else                       rpt_d = rpt_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rpt_q <= '0;
      else        rpt_q <= rpt_d;
   end

   assign emit_now = (state_q == EMIT) || rpt_fire;
`else
   assign emit_now = (state_q == EMIT);
`endif

   assign kp.col_n   = ~(5'd1 << col_q);
   assign kp.newhex  = emit_now && is_hex;
   assign kp.newop   = emit_now && is_op;
   assign kp.eq      = emit_now && is_eq;
   assign kp.hexcode = hex_q;
   assign kp.opcode  = op_q;

endmodule
